ref_angle_loader: RTL and testbench

Host-side source for the reference-angle fill path of the scoring pipeline. Holds one SEQ_LEN-entry reference sequence for each of the three limbs (upper, lower-left, lower-right), written by the host one word at a time. On command, it streams all three sequences in lockstep as a `fill` strobe plus three angle buses into the per-limb reference shift registers that feed the DTW engines. It is the transmitting end of the `fill` / `refer_in_*` interface.

---
 rtl/ref_angle_loader.sv | 235 +++++++++++++++++++++++
 tb/tb_ref_angle_loader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ref_angle_loader.sv
// Reference-angle loader: host-written per-limb sequences streamed in lockstep on fill/refer_out_*.
// Optional running checksums are built when REF_ANGLE_LOADER_CHECKSUM_EN is defined.
module ref_angle_loader #(
    parameter int ANGLE_DEPTH = 10,
    parameter int SEQ_LEN     = 22
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [1:0]                   wr_limb,
    input  logic [$clog2(SEQ_LEN)-1:0]   wr_addr,
    input  logic [ANGLE_DEPTH-1:0]       wr_data,
    output logic                         wr_err,
    input  logic                         start,
    input  logic                         hold,
    output logic                         fill,
    output logic [ANGLE_DEPTH-1:0]       refer_out_u,
    output logic [ANGLE_DEPTH-1:0]       refer_out_ll,
    output logic [ANGLE_DEPTH-1:0]       refer_out_lr,
    output logic                         busy,
    output logic                         done,
    output logic [ANGLE_DEPTH+4:0]       checksum_u,
    output logic [ANGLE_DEPTH+4:0]       checksum_ll,
    output logic [ANGLE_DEPTH+4:0]       checksum_lr
);

    localparam int AW = $clog2(SEQ_LEN);
    localparam int IW = AW + 1;
    localparam int CW = ANGLE_DEPTH + 5;
    localparam logic [IW-1:0] SEQ_LEN_W = IW'(SEQ_LEN);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                 state_r, state_s;
    logic [IW-1:0]          idx_r, idx_s;
    logic                   fill_r, fill_s;
    logic                   busy_r, busy_s;
    logic                   done_r, done_s;
    logic                   wr_err_r, wr_err_s;
    logic [ANGLE_DEPTH-1:0] out_u_r, out_u_s;
    logic [ANGLE_DEPTH-1:0] out_ll_r, out_ll_s;
    logic [ANGLE_DEPTH-1:0] out_lr_r, out_lr_s;

    logic                   wr_ok_s;
    logic                   wr_commit_s;
    logic [AW-1:0]          rd_addr_s;
    logic [ANGLE_DEPTH-1:0] rd_u_s, rd_ll_s, rd_lr_s;

    logic [ANGLE_DEPTH-1:0] mem_u_r  [SEQ_LEN];
    logic [ANGLE_DEPTH-1:0] mem_ll_r [SEQ_LEN];
    logic [ANGLE_DEPTH-1:0] mem_lr_r [SEQ_LEN];

    // Host write qualification: only in IDLE, valid limb and in-range address.
    always_comb begin
        wr_ok_s = 1'b0;
        if ((state_r == ST_IDLE) && (wr_limb != 2'd3) && ({1'b0, wr_addr} < SEQ_LEN_W)) begin
            wr_ok_s = 1'b1;
        end else begin
            wr_ok_s = 1'b0;
        end
    end

    assign wr_commit_s = wr_en & wr_ok_s & ~rst;

    // Read port; a write on the start edge is forwarded so the stream sees the new word.
    always_comb begin
        rd_addr_s = {AW{1'b0}};
        if ((state_r == ST_STREAM) && (idx_r < SEQ_LEN_W)) begin
            rd_addr_s = idx_r[AW-1:0];
        end else begin
            rd_addr_s = {AW{1'b0}};
        end
        rd_u_s  = mem_u_r[rd_addr_s];
        rd_ll_s = mem_ll_r[rd_addr_s];
        rd_lr_s = mem_lr_r[rd_addr_s];
        if (wr_commit_s && (wr_addr == rd_addr_s)) begin
            case (wr_limb)
                2'd0:    rd_u_s  = wr_data;
                2'd1:    rd_ll_s = wr_data;
                2'd2:    rd_lr_s = wr_data;
                default: rd_u_s  = mem_u_r[rd_addr_s];
            endcase
        end else begin
            rd_u_s  = mem_u_r[rd_addr_s];
        end
    end

    // Sequence storage; deliberately not reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_commit_s) begin
            case (wr_limb)
                2'd0:    mem_u_r[wr_addr]  <= wr_data;
                2'd1:    mem_ll_r[wr_addr] <= wr_data;
                2'd2:    mem_lr_r[wr_addr] <= wr_data;
                default: mem_u_r[wr_addr]  <= mem_u_r[wr_addr];
            endcase
        end
    end

    // Next-state and next-output logic; idx counts words already presented.
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        fill_s   = 1'b0;
        busy_s   = busy_r;
        done_s   = 1'b0;
        wr_err_s = wr_en & ~wr_ok_s;
        out_u_s  = out_u_r;
        out_ll_s = out_ll_r;
        out_lr_s = out_lr_r;
        case (state_r)
            ST_IDLE: begin
                idx_s = {IW{1'b0}};
                if (start) begin
                    state_s = ST_STREAM;
                    busy_s  = 1'b1;
                    if (!hold) begin
                        fill_s   = 1'b1;
                        out_u_s  = rd_u_s;
                        out_ll_s = rd_ll_s;
                        out_lr_s = rd_lr_s;
                        idx_s    = {{(IW-1){1'b0}}, 1'b1};
                    end else begin
                        fill_s = 1'b0;
                    end
                end else begin
                    busy_s = 1'b0;
                end
            end
            ST_STREAM: begin
                if (idx_r >= SEQ_LEN_W) begin
                    state_s = ST_DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else if (!hold) begin
                    fill_s   = 1'b1;
                    out_u_s  = rd_u_s;
                    out_ll_s = rd_ll_s;
                    out_lr_s = rd_lr_s;
                    idx_s    = idx_r + 1'b1;
                end else begin
                    fill_s = 1'b0;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                idx_s   = {IW{1'b0}};
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                idx_s   = {IW{1'b0}};
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            idx_r    <= {IW{1'b0}};
            fill_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            wr_err_r <= 1'b0;
            out_u_r  <= {ANGLE_DEPTH{1'b0}};
            out_ll_r <= {ANGLE_DEPTH{1'b0}};
            out_lr_r <= {ANGLE_DEPTH{1'b0}};
        end else begin
            state_r  <= state_s;
            idx_r    <= idx_s;
            fill_r   <= fill_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            wr_err_r <= wr_err_s;
            out_u_r  <= out_u_s;
            out_ll_r <= out_ll_s;
            out_lr_r <= out_lr_s;
        end
    end

    assign fill         = fill_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign wr_err       = wr_err_r;
    assign refer_out_u  = out_u_r;
    assign refer_out_ll = out_ll_r;
    assign refer_out_lr = out_lr_r;

`ifdef REF_ANGLE_LOADER_CHECKSUM_EN
    logic [CW-1:0] cs_u_r, cs_u_s;
    logic [CW-1:0] cs_ll_r, cs_ll_s;
    logic [CW-1:0] cs_lr_r, cs_lr_s;
    logic          clear_s;

    function automatic logic [CW-1:0] widen(input logic [ANGLE_DEPTH-1:0] a);
        return {{5{1'b0}}, a};
    endfunction

    // Sums restart on an accepted start and add each word as it is filled.
    always_comb begin
        clear_s = (state_r == ST_IDLE) && start;
        cs_u_s  = (clear_s ? {CW{1'b0}} : cs_u_r)  + (fill_s ? widen(out_u_s)  : {CW{1'b0}});
        cs_ll_s = (clear_s ? {CW{1'b0}} : cs_ll_r) + (fill_s ? widen(out_ll_s) : {CW{1'b0}});
        cs_lr_s = (clear_s ? {CW{1'b0}} : cs_lr_r) + (fill_s ? widen(out_lr_s) : {CW{1'b0}});
    end

    // Checksum registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_u_r  <= {CW{1'b0}};
            cs_ll_r <= {CW{1'b0}};
            cs_lr_r <= {CW{1'b0}};
        end else begin
            cs_u_r  <= cs_u_s;
            cs_ll_r <= cs_ll_s;
            cs_lr_r <= cs_lr_s;
        end
    end

    assign checksum_u  = cs_u_r;
    assign checksum_ll = cs_ll_r;
    assign checksum_lr = cs_lr_r;
`else
    assign checksum_u  = {CW{1'b0}};
    assign checksum_ll = {CW{1'b0}};
    assign checksum_lr = {CW{1'b0}};
`endif

endmodule

// File: tb/tb_ref_angle_loader.sv
// Self-checking bench for ref_angle_loader against a cycle-level behavioural model.
module tb_ref_angle_loader;

    localparam int SL = 22;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, wr_en = 1'b0, start = 1'b0, hold = 1'b0;
    logic [1:0] wr_limb = 2'd0;
    logic [4:0] wr_addr = 5'd0;
    logic [9:0] wr_data = 10'd0;
    logic       wr_err, fill, busy, done;
    logic [9:0] ro_u, ro_ll, ro_lr;
    logic [14:0] cs_u, cs_ll, cs_lr;

    ref_angle_loader dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_limb(wr_limb), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_err(wr_err), .start(start), .hold(hold), .fill(fill),
        .refer_out_u(ro_u), .refer_out_ll(ro_ll), .refer_out_lr(ro_lr),
        .busy(busy), .done(done),
        .checksum_u(cs_u), .checksum_ll(cs_ll), .checksum_lr(cs_lr)
    );

    int n_cmp = 0, n_fail = 0;

    // Model: stored sequences, stream progress and expected outputs
    logic [9:0]  mu [SL], ml [SL], mr [SL];
    bit          m_on = 1'b0, m_in_done = 1'b0;
    int          m_k = 0;
    logic        e_err = 1'b0, e_fill = 1'b0, e_busy = 1'b0, e_done = 1'b0;
    logic [9:0]  e_u = 10'd0, e_ll = 10'd0, e_lr = 10'd0;
    logic [14:0] s_u = 15'd0, s_ll = 15'd0, s_lr = 15'd0;

    logic [78:0] obs;
    assign obs = {fill, busy, done, wr_err, ro_u, ro_ll, ro_lr, cs_u, cs_ll, cs_lr};

    function automatic logic [78:0] exp_vec();
`ifdef REF_ANGLE_LOADER_CHECKSUM_EN
        return {e_fill, e_busy, e_done, e_err, e_u, e_ll, e_lr, s_u, s_ll, s_lr};
`else
        return {e_fill, e_busy, e_done, e_err, e_u, e_ll, e_lr, 45'd0};
`endif
    endfunction

    task automatic present();
        if (!hold) begin
            e_fill = 1'b1;
            e_u = mu[m_k]; e_ll = ml[m_k]; e_lr = mr[m_k];
            s_u = s_u + {5'd0, e_u}; s_ll = s_ll + {5'd0, e_ll}; s_lr = s_lr + {5'd0, e_lr};
            m_k++;
        end
    endtask

    // Apply the behavioural rules to the inputs about to be sampled on the next edge.
    task automatic model_edge();
        bit acc;
        acc = wr_en && !m_on && !m_in_done && (wr_limb != 2'd3) && (wr_addr < 5'd22);
        if (rst) begin
            {e_err, e_fill, e_busy, e_done} = 4'b0;
            e_u = 10'd0; e_ll = 10'd0; e_lr = 10'd0;
            s_u = 15'd0; s_ll = 15'd0; s_lr = 15'd0;
            m_on = 1'b0; m_in_done = 1'b0; m_k = 0;
        end else begin
            e_err = wr_en && !acc;
            if (acc) begin
                if (wr_limb == 2'd0) mu[wr_addr] = wr_data;
                else if (wr_limb == 2'd1) ml[wr_addr] = wr_data;
                else mr[wr_addr] = wr_data;
            end
            e_done = 1'b0; e_fill = 1'b0;
            if (m_in_done) begin
                m_in_done = 1'b0; e_busy = 1'b0;
            end else if (!m_on) begin
                if (start) begin
                    m_on = 1'b1; m_k = 0; e_busy = 1'b1;
                    s_u = 15'd0; s_ll = 15'd0; s_lr = 15'd0;
                    present();
                end else begin
                    e_busy = 1'b0;
                end
            end else if (m_k == SL) begin
                e_done = 1'b1; e_busy = 1'b0; m_on = 1'b0; m_in_done = 1'b1;
            end else begin
                present();
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        if (obs !== exp_vec()) begin
            n_fail++; $display("FAIL reset: got %h want %h", obs, exp_vec());
        end
        n_cmp++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int first_done;
        for (int i = 0; i < SL; i++) begin
            for (int l = 0; l < 3; l++) begin
                wr_en = 1'b1; wr_limb = 2'(l); wr_addr = 5'(i); wr_data = 10'(l * 100 + i);
                step();
                wr_en = 1'b0;
                if (obs !== exp_vec()) begin
                    n_fail++; $display("FAIL basic_write %0d/%0d: got %h want %h", l, i, obs, exp_vec());
                end
                n_cmp++;
            end
        end
        first_done = 0;
        start = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            step();
            start = 1'b0;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL basic_stream cycle T+%0d: got %h want %h", n, obs, exp_vec());
            end
            n_cmp++;
            if (done === 1'b1 && first_done == 0) begin
                first_done = n;
`ifdef REF_ANGLE_LOADER_CHECKSUM_EN
                if ({cs_u, cs_ll, cs_lr} !== {15'd231, 15'd2431, 15'd4631}) begin
                    n_fail++; $display("FAIL basic_checksum: got %0d %0d %0d want 231 2431 4631", cs_u, cs_ll, cs_lr);
                end
`else
                if ({cs_u, cs_ll, cs_lr} !== 45'd0) begin
                    n_fail++; $display("FAIL basic_checksum: got %0d %0d %0d want 0 0 0", cs_u, cs_ll, cs_lr);
                end
`endif
                n_cmp++;
            end
        end
        if (first_done !== 23) begin
            n_fail++; $display("FAIL basic_done_cycle: got T+%0d want T+23", first_done);
        end
        n_cmp++;
    endtask

    task automatic test_hold();
        int first_done;
        first_done = 0;
        start = 1'b1;
        for (int n = 1; n <= 27; n++) begin
            hold = (n >= 7 && n <= 9);
            step();
            start = 1'b0;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL hold_stream cycle T+%0d: got %h want %h", n, obs, exp_vec());
            end
            n_cmp++;
            if (done === 1'b1 && first_done == 0) first_done = n;
        end
        hold = 1'b0;
        if (first_done !== 26) begin
            n_fail++; $display("FAIL hold_done_cycle: got T+%0d want T+26", first_done);
        end
        n_cmp++;
    endtask

    task automatic test_bad_writes();
        wr_en = 1'b1; wr_limb = 2'd3; wr_addr = 5'd2; wr_data = 10'd777;
        step();
        wr_en = 1'b0;
        if (obs !== exp_vec()) begin
            n_fail++; $display("FAIL bad_limb: got %h want %h", obs, exp_vec());
        end
        n_cmp++;
        wr_en = 1'b1; wr_limb = 2'd0; wr_addr = 5'd22; wr_data = 10'd555;
        step();
        wr_en = 1'b0;
        if (obs !== exp_vec()) begin
            n_fail++; $display("FAIL bad_addr: got %h want %h", obs, exp_vec());
        end
        n_cmp++;
        for (int s = 0; s < 2; s++) begin
            start = 1'b1;
            for (int n = 1; n <= 24; n++) begin
                if (s == 0 && n == 3) begin
                    wr_en = 1'b1; wr_limb = 2'd1; wr_addr = 5'd4; wr_data = 10'd999;
                end
                step();
                start = 1'b0; wr_en = 1'b0;
                if (obs !== exp_vec()) begin
                    n_fail++; $display("FAIL bad_write_stream%0d cycle T+%0d: got %h want %h", s, n, obs, exp_vec());
                end
                n_cmp++;
            end
        end
    endtask

    task automatic test_start_ignored();
        int dones;
        dones = 0;
        for (int n = 1; n <= 30; n++) begin
            start = (n == 1 || n == 11 || n == 24);
            step();
            start = 1'b0;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL start_ignored cycle T+%0d: got %h want %h", n, obs, exp_vec());
            end
            n_cmp++;
            if (done === 1'b1) dones++;
        end
        if (dones !== 1) begin
            n_fail++; $display("FAIL start_ignored_dones: got %0d want 1", dones);
        end
        n_cmp++;
    endtask

    task automatic test_rst_mid();
        int dones, first_done;
        dones = 0;
        first_done = 0;
        start = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            rst = (n == 9);
            step();
            start = 1'b0; rst = 1'b0;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL rst_mid cycle T+%0d: got %h want %h", n, obs, exp_vec());
            end
            n_cmp++;
            if (done === 1'b1) dones++;
        end
        if (dones !== 0) begin
            n_fail++; $display("FAIL rst_mid_dones: got %0d want 0", dones);
        end
        n_cmp++;
        start = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            step();
            start = 1'b0;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL rst_restart cycle T+%0d: got %h want %h", n, obs, exp_vec());
            end
            n_cmp++;
            if (done === 1'b1 && first_done == 0) first_done = n;
        end
        if (first_done !== 23) begin
            n_fail++; $display("FAIL rst_restart_done_cycle: got T+%0d want T+23", first_done);
        end
        n_cmp++;
    endtask

    task automatic test_random();
        bit finished;
        for (int r = 0; r < 5; r++) begin
            for (int w = 0; w < 20; w++) begin
                wr_en = 1'b1;
                wr_limb = 2'($urandom_range(0, 3));
                wr_addr = 5'($urandom_range(0, 23));
                wr_data = 10'($urandom);
                step();
                wr_en = 1'b0;
                if (obs !== exp_vec()) begin
                    n_fail++; $display("FAIL random_write r%0d w%0d: got %h want %h", r, w, obs, exp_vec());
                end
                n_cmp++;
            end
            finished = 1'b0;
            start = 1'b1;
            wr_en = 1'b1; wr_limb = 2'($urandom_range(0, 2)); wr_addr = 5'($urandom_range(0, 1));
            wr_data = 10'($urandom);
            for (int n = 1; n <= 100 && !finished; n++) begin
                hold = ($urandom_range(0, 3) == 0);
                step();
                start = ($urandom_range(0, 9) == 0);
                wr_en = ($urandom_range(0, 9) == 0);
                wr_data = 10'($urandom);
                if (obs !== exp_vec()) begin
                    n_fail++; $display("FAIL random_stream r%0d cycle %0d: got %h want %h", r, n, obs, exp_vec());
                end
                n_cmp++;
                if (e_done) finished = 1'b1;
            end
            start = 1'b0; wr_en = 1'b0; hold = 1'b0;
            if (!finished) begin
                n_fail++; $display("FAIL random_timeout r%0d: got no done want done", r);
            end
            n_cmp++;
            step();
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL random_idle r%0d: got %h want %h", r, obs, exp_vec());
            end
            n_cmp++;
        end
    endtask

    initial begin
        for (int i = 0; i < SL; i++) begin
            mu[i] = 10'd0; ml[i] = 10'd0; mr[i] = 10'd0;
        end
        test_reset();
        test_basic();
        test_hold();
        test_bad_writes();
        test_start_ignored();
        test_rst_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
